// File: rtl/intersection_ctrl.sv
// Two-road intersection controller: NS/EW greens with demand-driven dwell,
// yellow and all-red clearance, and a pedestrian walk phase between greens.
module intersection_ctrl #(
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 12,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned WALK_T    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_ns,
    input  logic       req_ew,
    input  logic       ped_req,
    output logic [1:0] light_ns,
    output logic [1:0] light_ew,
    output logic       walk,
    output logic [2:0] phase
);

    localparam int unsigned TW = 8;

    // Last timer value of each dwell (a dwell of N occupies timer values 0..N-1)
    localparam logic [TW-1:0] GMIN_LAST   = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX_LAST   = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] WALK_LAST   = TW'(WALK_T - 1);

    localparam logic [1:0] LAMP_G = 2'b00;
    localparam logic [1:0] LAMP_Y = 2'b01;
    localparam logic [1:0] LAMP_R = 2'b10;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        PED_WALK  = 3'd6
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            ped_pend_q, ped_pend_d;
    logic            dir_q, dir_d;       // 1: EW_GREEN follows the walk, 0: NS_GREEN
    logic [1:0]      light_ns_q, light_ns_d;
    logic [1:0]      light_ew_q, light_ew_d;
    logic            walk_q, walk_d;

    // State, timer, pedestrian latch and registered lamp outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= NS_GREEN;
            timer_q    <= '0;
            ped_pend_q <= 1'b0;
            dir_q      <= 1'b0;
            light_ns_q <= LAMP_G;
            light_ew_q <= LAMP_R;
            walk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ped_pend_q <= ped_pend_d;
            dir_q      <= dir_d;
            light_ns_q <= light_ns_d;
            light_ew_q <= light_ew_d;
            walk_q     <= walk_d;
        end
    end

    // Next-state, dwell timer, pedestrian latch and lamp decode of the next state
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        ped_pend_d = ped_pend_q;
        light_ns_d = LAMP_R;
        light_ew_d = LAMP_R;
        walk_d     = 1'b0;

        unique case (state_q)
            NS_GREEN: begin
                if (((timer_q >= GMIN_LAST) && (req_ew || ped_pend_q)) || (timer_q == GMAX_LAST))
                    state_d = NS_YELLOW;
            end
            NS_YELLOW: begin
                if (timer_q == YELLOW_LAST) state_d = ALLRED_A;
            end
            ALLRED_A: begin
                if (timer_q == ALLRED_LAST) begin
                    if (ped_pend_q) begin
                        state_d = PED_WALK;
                        dir_d   = 1'b1;
                    end else begin
                        state_d = EW_GREEN;
                    end
                end
            end
            EW_GREEN: begin
                if (((timer_q >= GMIN_LAST) && (req_ns || ped_pend_q)) || (timer_q == GMAX_LAST))
                    state_d = EW_YELLOW;
            end
            EW_YELLOW: begin
                if (timer_q == YELLOW_LAST) state_d = ALLRED_B;
            end
            ALLRED_B: begin
                if (timer_q == ALLRED_LAST) begin
                    if (ped_pend_q) begin
                        state_d = PED_WALK;
                        dir_d   = 1'b0;
                    end else begin
                        state_d = NS_GREEN;
                    end
                end
            end
            PED_WALK: begin
                if (timer_q == WALK_LAST) state_d = dir_q ? EW_GREEN : NS_GREEN;
            end
            default: state_d = ALLRED_B;
        endcase

        // Button presses latch outside the walk; entering the walk consumes the latch
        if (ped_req && (state_q != PED_WALK)) ped_pend_d = 1'b1;
        if ((state_d == PED_WALK) && (state_q != PED_WALK)) ped_pend_d = 1'b0;

        timer_d = (state_d != state_q) ? '0 : timer_q + TW'(1);

        unique case (state_d)
            NS_GREEN:  light_ns_d = LAMP_G;
            NS_YELLOW: light_ns_d = LAMP_Y;
            EW_GREEN:  light_ew_d = LAMP_G;
            EW_YELLOW: light_ew_d = LAMP_Y;
            PED_WALK:  walk_d     = 1'b1;
            default:   ;
        endcase
    end

    assign light_ns = light_ns_q;
    assign light_ew = light_ew_q;
    assign walk     = walk_q;
    assign phase    = state_q;

endmodule
